// File: rtl/grf_regfile_if.sv
// Register-file port bundle: two combinational read ports and the write-back write port.
// The write-back stage / decode stage side is the master; grf_regfile is the slave.
interface grf_regfile_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [4:0]  A3;
    logic        WE3;
    logic [31:0] WD3;
    logic [31:0] WPC;

    modport master (
        output A1, A2, A3, WE3, WD3, WPC,
        input  RD1, RD2
    );

    modport slave (
        input  A1, A2, A3, WE3, WD3, WPC,
        output RD1, RD2
    );
endinterface

// File: rtl/grf_regfile.sv
// 32x32 MIPS general register file with $0 hardwired to zero, commit trace and write counter.
// Optional macro GRF_BYPASS_EN: same-cycle write-to-read forwarding on both read ports.
module grf_regfile #(
    parameter int NREG          = 32,
    parameter int TRACE_DEPTH_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    grf_regfile_if.slave             grf,
    output logic                     trace_valid,
    output logic [31:0]              trace_pc,
    output logic [4:0]               trace_num,
    output logic [31:0]              trace_data,
    output logic [TRACE_DEPTH_W-1:0] write_count
);

    logic [31:0] regs [1:NREG-1];
    logic        commit;

    // Gating with reset_n keeps the bypass path from leaking WD3 while in reset.
    assign commit = reset_n && grf.WE3 && (grf.A3 != 5'd0);

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] data;
        if (addr == 5'd0) begin
            data = 32'd0;
        end else begin
            data = regs[addr];
`ifdef GRF_BYPASS_EN
            if (commit && (grf.A3 == addr)) begin
                data = grf.WD3;
            end
`endif
        end
        return data;
    endfunction

    always_comb begin
        grf.RD1 = read_port(grf.A1);
        grf.RD2 = read_port(grf.A2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (commit) begin
            regs[grf.A3] <= grf.WD3;
        end
    end

    // Trace stage: reflects the commit of the previous edge; payload holds between commits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trace_valid <= 1'b0;
            trace_pc    <= 32'd0;
            trace_num   <= 5'd0;
            trace_data  <= 32'd0;
            write_count <= '0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                trace_pc    <= grf.WPC;
                trace_num   <= grf.A3;
                trace_data  <= grf.WD3;
                write_count <= write_count + TRACE_DEPTH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_grf_regfile.sv
// Randomized scoreboard bench for grf_regfile; a second instance with a 4-bit counter checks wrap.
module tb_grf_regfile;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    grf_regfile_if bus ();
    grf_regfile_if bus4 ();

    logic        trace_valid, trace_valid4;
    logic [31:0] trace_pc, trace_pc4;
    logic [4:0]  trace_num, trace_num4;
    logic [31:0] trace_data, trace_data4;
    logic [31:0] write_count;
    logic [3:0]  write_count4;

    grf_regfile #(.NREG(32), .TRACE_DEPTH_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .grf(bus.slave),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_num(trace_num),
        .trace_data(trace_data), .write_count(write_count)
    );

    grf_regfile #(.NREG(32), .TRACE_DEPTH_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .grf(bus4.slave),
        .trace_valid(trace_valid4), .trace_pc(trace_pc4), .trace_num(trace_num4),
        .trace_data(trace_data4), .write_count(write_count4)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rd1, rd2, wc, tpc, tdata;
        logic [3:0]  wc4;
        logic [4:0]  tnum;
        logic        tv;
    } entry_t;

    entry_t sbq[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: architectural registers, commit count, and last committed write.
    logic [31:0] mreg [32];
    logic [31:0] mcnt;
    logic        m_tv;
    logic [31:0] m_tpc, m_tdata;
    logic [4:0]  m_tnum;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mcnt = 32'd0; m_tv = 1'b0; m_tpc = 32'd0; m_tdata = 32'd0; m_tnum = 5'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic cm,
                                               input logic [4:0] a3, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
        if (cm && a3 == a) return wd;
`endif
        return mreg[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus; mid=1 drops reset_n between edges after driving.
    task automatic step(input logic rn, input logic mid, input logic [4:0] a1, input logic [4:0] a2,
                        input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] wpc);
        entry_t e;
        logic   eff_rn, cm;
        @(posedge clk);
        #1;
        reset_n = rn;
        bus.A1 = a1;  bus.A2 = a2;  bus.A3 = a3;  bus.WE3 = we;  bus.WD3 = wd;  bus.WPC = wpc;
        bus4.A1 = a1; bus4.A2 = a2; bus4.A3 = a3; bus4.WE3 = we; bus4.WD3 = wd; bus4.WPC = wpc;
        if (mid) begin
            #1;
            reset_n = 1'b0;
        end
        eff_rn = rn && !mid;
        if (!eff_rn) model_reset();
        cm = eff_rn && we && (a3 != 5'd0);
        e.cyc = cyc;
        e.rd1 = model_read(a1, cm, a3, wd);
        e.rd2 = model_read(a2, cm, a3, wd);
        e.wc = mcnt; e.wc4 = mcnt[3:0];
        e.tv = m_tv; e.tpc = m_tpc; e.tnum = m_tnum; e.tdata = m_tdata;
        sbq.push_back(e);
        m_tv = cm;
        if (cm) begin
            mreg[a3] = wd;
            mcnt = mcnt + 32'd1;
            m_tpc = wpc; m_tnum = a3; m_tdata = wd;
        end
    endtask

    always @(negedge clk) begin
        entry_t e;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            chk("rd1", bus.RD1, e.rd1);
            chk("rd2", bus.RD2, e.rd2);
            chk("write_count", write_count, e.wc);
            chk("write_count_w4", {28'd0, write_count4}, {28'd0, e.wc4});
            chk("trace_valid", {31'd0, trace_valid}, {31'd0, e.tv});
            chk("trace_pc", trace_pc, e.tpc);
            chk("trace_num", {27'd0, trace_num}, {27'd0, e.tnum});
            chk("trace_data", trace_data, e.tdata);
        end
    end

    initial begin
        logic [4:0] ra3;
        model_reset();
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.WE3 = 1'b0; bus.WD3 = '0; bus.WPC = '0;
        bus4.A1 = '0; bus4.A2 = '0; bus4.A3 = '0; bus4.WE3 = 1'b0; bus4.WD3 = '0; bus4.WPC = '0;

        // Reset sweep with write attempts that must neither land nor bypass.
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b0, 5'(i), 5'(31 - i), 1'b1, 5'(i), $urandom, $urandom);

        // Basic write/read and trace.
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_3010);
        step(1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        // $0 discard.
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3014);
        step(1'b1, 1'b0, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 32'd0);
        // Same-cycle read of the write target.
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h0000_0001, 32'h0000_3018);
        step(1'b1, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0000_301C);
        step(1'b1, 1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 32'd0);
        // Back-to-back commits to one register.
        step(1'b1, 1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h1111_1111, 32'h0000_3020);
        step(1'b1, 1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h2222_2222, 32'h0000_3024);
        step(1'b1, 1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 32'd0);
        // Asynchronous reset between edges, with a commit presented in that cycle.
        step(1'b1, 1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 32'h0000_00AA, 32'h0000_3028);
        step(1'b1, 1'b1, 5'd3, 5'd7, 1'b1, 5'd4, 32'h5555_5555, 32'h0000_302C);
        step(1'b0, 1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 32'd0);

        // Counter wrap on the 4-bit instance: 17 commits to reg 1.
        for (int i = 0; i < 17; i++)
            step(1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 5'd1, 32'(i + 100), 32'h0000_4000 + 32'(4 * i));
        step(1'b1, 1'b0, 5'd1, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0);

        // Randomized traffic with occasional mid-stream resets.
        for (int n = 0; n < 400; n++) begin
            ra3 = 5'($urandom_range(0, 31));
            step(1'b1, ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0) ? ra3 : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? ra3 : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) < 7), ra3, $urandom, $urandom);
        end
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0);

        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grf_regfile.md
# grf_regfile

General register file for the five-stage MIPS pipeline: the write-port receiver for the write-back stage's `GRF_A3`/`WE3`/`Write_GRF_Data` triple, and the read-port source for the decode stage. It holds 32 × 32-bit registers with `$0` hardwired to zero. It also provides optional write-to-read bypass and a registered commit-trace port for the bench and the later exception/debug logic.

## Interface
- `NREG`, 32: register count; fixed, address width 5.
- `TRACE_DEPTH_W`, 32: width of the committed-write counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `A1` input 5: read port 1 address (rs).
- `A2` input 5: read port 2 address (rt).
- `RD1` output 32: read port 1 data, combinational.
- `RD2` output 32: read port 2 data, combinational.
- `A3` input 5: write address, driven by write-back `GRF_A3`.
- `WE3` input 1: write enable, driven by write-back `WE3`.
- `WD3` input 32: write data, driven by write-back `Write_GRF_Data`.
- `WPC` input 32: PC of the instruction in write-back, used for trace only.
- `trace_valid` output 1: one-cycle pulse after a committed write to a nonzero register.
- `trace_pc` output 32: `WPC` of the last committed write.
- `trace_num` output 5: register number of the last committed write.
- `trace_data` output 32: value of the last committed write.
- `write_count` output `TRACE_DEPTH_W`: number of committed writes since reset.

## Operation
- Storage: registers 1..31 are flops. Register 0 is not stored. It always reads 0, and writes to it are discarded.
- Commit condition: `WE3 && A3 != 0`, sampled on the rising edge of `clk`.
  - On commit: `reg[A3] <= WD3`.
  - Otherwise: no storage change.
- Read path:
  - `RDn = (An == 0) ? 0 : reg[An]`.
  - When `GRF_BYPASS_EN` is compiled in and a commit is pending this cycle with `A3 == An`, `RDn` returns `WD3` instead.
- Trace register, updated every rising edge:
  - `trace_valid <= commit`.
  - On commit only: `trace_pc <= WPC`, `trace_num <= A3`, `trace_data <= WD3`.
  - On non-commit cycles: `trace_pc`, `trace_num` and `trace_data` hold their previous values.
- Counter: `write_count` increments by 1 on each commit and wraps modulo 2^`TRACE_DEPTH_W`.
- `WE3 = 1` with `A3 = 0` is a legal non-commit. It produces no trace pulse and no counter increment.

## Timing
- Reset (`reset_n` low, asynchronous, takes effect immediately without waiting for `clk`):
  - Registers 1..31 = 0.
  - `trace_valid` = 0, `trace_pc` = 0, `trace_num` = 0, `trace_data` = 0, `write_count` = 0.
  - `RD1` and `RD2` read 0 for every address while in reset.
- Reset release: the first commit can occur on the first rising edge with `reset_n` high.
- Reset mid-operation: a commit presented in the same cycle that `reset_n` falls is lost; reset wins.
- Write latency: the new value is visible on `RD1`/`RD2` from the cycle after the commit edge without bypass, and in the same cycle with bypass.
- Trace latency: `trace_*` reflects a commit in the cycle immediately after its edge.
- Simultaneous events:
  - `A1 == A2 == A3` with bypass: both read ports return `WD3`.
  - Back-to-back commits to the same register: the last one wins; each produces its own trace pulse.
- Read ports are purely combinational from `A1`/`A2`, storage and, under bypass, `A3`/`WE3`/`WD3`. There is no read enable and no read latency.

## Configuration
- `GRF_BYPASS_EN`
  - Defined: internal write-to-read forwarding as described under Operation. This lets the hazard unit drop the W→D forward path.
  - Undefined: reads during a commit cycle return the pre-write value. The hazard unit must supply W→D forwarding externally.
  - Storage, trace and counter behaviour are identical in both builds.

## Test plan
- Reset: hold `reset_n` = 0, then release.
  - During reset, read all 32 addresses on both ports: all return 0.
  - After release: `trace_valid` = 0 and `write_count` = 0.
- Basic write/read: `WE3` = 1, `A3` = 5, `WD3` = 0x1234_5678, `WPC` = 0x0000_3010.
  - Next cycle: `RD1` with `A1` = 5 returns 0x1234_5678.
  - Next cycle: `trace_valid` = 1, `trace_num` = 5, `trace_pc` = 0x0000_3010, `write_count` = 1.
- `$0` discard: `WE3` = 1, `A3` = 0, `WD3` = 0xFFFF_FFFF.
  - `RD1` with `A1` = 0 stays 0 in all cycles.
  - `trace_valid` stays 0 and `write_count` is unchanged.
- Same-cycle read of the write target: `A1` = `A2` = `A3` = 7, `WD3` = 0xDEAD_BEEF, reg7 holds 0x1.
  - Bypass build: both ports read 0xDEAD_BEEF in that cycle.
  - Non-bypass build: both ports read 0x1 in that cycle and 0xDEAD_BEEF in the next.
- Asynchronous reset mid-stream: commit reg3 = 0xAA, then drop `reset_n` between clock edges.
  - `RD1` with `A1` = 3 goes to 0 before the next edge.
  - `write_count` = 0 and all `trace_*` = 0.
- Counter wrap (`TRACE_DEPTH_W` overridden to 4): perform 17 commits to reg 1 → `write_count` = 1.
